// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 single-precision multiplier with valid/ready on both sides.
// Operands are captured on acceptance, then unpack (S1), multiply (S2) and round/pack (S3).
module fmul_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        ovf
);

  logic        stall;
  logic        v0_reg, v1_reg, v2_reg, v3_reg;
  logic [31:0] a_reg, b_reg;

  logic        s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg;
  logic [9:0]  s1_exp_reg;
  logic [23:0] s1_ma_reg, s1_mb_reg;

  logic        s2_sign_reg, s2_nan_reg, s2_inf_reg, s2_zero_reg;
  logic [9:0]  s2_exp_reg;
  logic [47:0] s2_prod_reg;

  logic [31:0] q_reg;
  logic        ovf_reg;

  assign stall     = v3_reg & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_reg;
  assign q         = q_reg;
  assign ovf       = ovf_reg;

  // Per-operand unpack; exponent 0 (zero or denormal) is treated as zero.
  logic [31:0] op       [2];
  logic [7:0]  op_exp   [2];
  logic [23:0] op_man   [2];
  logic        op_zero  [2];
  logic        op_inf   [2];
  logic        op_nan   [2];

  assign op[0] = a_reg;
  assign op[1] = b_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_exp[gi]  = op[gi][30:23];
      assign op_zero[gi] = (op_exp[gi] == 8'h00);
      assign op_inf[gi]  = (op_exp[gi] == 8'hFF) && (op[gi][22:0] == 23'd0);
      assign op_nan[gi]  = (op_exp[gi] == 8'hFF) && (op[gi][22:0] != 23'd0);
      assign op_man[gi]  = {~op_zero[gi], op[gi][22:0]};
    end
  endgenerate

  logic       s1_nan_next, s1_inf_next, s1_zero_next;
  logic [9:0] s1_exp_next;

  always_comb begin
    s1_nan_next  = op_nan[0] | op_nan[1] | (op_inf[0] & op_zero[1]) | (op_zero[0] & op_inf[1]);
    s1_inf_next  = (op_inf[0] | op_inf[1]) & ~s1_nan_next;
    s1_zero_next = (op_zero[0] | op_zero[1]) & ~s1_nan_next & ~s1_inf_next;
    s1_exp_next  = {2'b00, op_exp[0]} + {2'b00, op_exp[1]} - 10'd127;
  end

  // S3: normalise, round to nearest even, then pack with overflow/flush handling.
  logic               norm_hi, guard, sticky, round_up;
  logic [22:0]        mant_t;
  logic [23:0]        mant_r;
  logic signed [10:0] exp_n, exp_f;
  logic [31:0]        q_next;
  logic               ovf_next;

  always_comb begin
    norm_hi = s2_prod_reg[47];
    if (norm_hi) begin
      mant_t = s2_prod_reg[46:24];
      guard  = s2_prod_reg[23];
      sticky = |s2_prod_reg[22:0];
    end else begin
      mant_t = s2_prod_reg[45:23];
      guard  = s2_prod_reg[22];
      sticky = |s2_prod_reg[21:0];
    end
    round_up = guard & (sticky | mant_t[0]);
    mant_r   = {1'b0, mant_t} + {23'd0, round_up};
    exp_n    = $signed({s2_exp_reg[9], s2_exp_reg}) + $signed({10'd0, norm_hi});
    exp_f    = exp_n + $signed({10'd0, mant_r[23]});

    ovf_next = 1'b0;
    if (s2_nan_reg) begin
      q_next = 32'h7FC0_0000;
    end else if (s2_inf_reg) begin
      q_next = {s2_sign_reg, 8'hFF, 23'd0};
    end else if (s2_zero_reg) begin
      q_next = {s2_sign_reg, 31'd0};
    end else if (exp_f >= 11'sd255) begin
      q_next   = {s2_sign_reg, 8'hFF, 23'd0};
      ovf_next = 1'b1;
    end else if (exp_f <= 11'sd0) begin
      q_next = {s2_sign_reg, 31'd0};
    end else begin
      q_next = {s2_sign_reg, exp_f[7:0], mant_r[22:0]};
    end
  end

  // Global stall: every stage, valid or not, holds while the output is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_reg      <= 1'b0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      v3_reg      <= 1'b0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      s1_sign_reg <= 1'b0;
      s1_nan_reg  <= 1'b0;
      s1_inf_reg  <= 1'b0;
      s1_zero_reg <= 1'b0;
      s1_exp_reg  <= 10'd0;
      s1_ma_reg   <= 24'd0;
      s1_mb_reg   <= 24'd0;
      s2_sign_reg <= 1'b0;
      s2_nan_reg  <= 1'b0;
      s2_inf_reg  <= 1'b0;
      s2_zero_reg <= 1'b0;
      s2_exp_reg  <= 10'd0;
      s2_prod_reg <= 48'd0;
      q_reg       <= 32'd0;
      ovf_reg     <= 1'b0;
    end else if (!stall) begin
      v0_reg      <= in_valid;
      a_reg       <= a;
      b_reg       <= b;

      v1_reg      <= v0_reg;
      s1_sign_reg <= op[0][31] ^ op[1][31];
      s1_nan_reg  <= s1_nan_next;
      s1_inf_reg  <= s1_inf_next;
      s1_zero_reg <= s1_zero_next;
      s1_exp_reg  <= s1_exp_next;
      s1_ma_reg   <= op_man[0];
      s1_mb_reg   <= op_man[1];

      v2_reg      <= v1_reg;
      s2_sign_reg <= s1_sign_reg;
      s2_nan_reg  <= s1_nan_reg;
      s2_inf_reg  <= s1_inf_reg;
      s2_zero_reg <= s1_zero_reg;
      s2_exp_reg  <= s1_exp_reg;
      s2_prod_reg <= s1_ma_reg * s1_mb_reg;

      v3_reg      <= v2_reg;
      q_reg       <= q_next;
      ovf_reg     <= ovf_next;
    end
  end

endmodule
